debounce_sync: RTL and testbench

- Conditions one raw asynchronous input (switch, pin, or cross-domain level) into a clean, clock-aligned level.
- Its q/notq output pair drives the data input of the async set/reset dff storage stage directly downstream.
- Function: multi-stage synchronizer, then a counter-based debounce FSM, plus single-cycle rise/fall pulses.
- Supports an asynchronous set override that mirrors the downstream flop's set semantics.

---
 rtl/debounce_sync_if.sv | 42 ++++
 rtl/debounce_sync.sv | 200 ++++++++++++++++++++
 tb/tb_debounce_sync.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/debounce_sync_if.sv
// Signal bundle for debounce_sync.
//   set  : asynchronous, active-high force of q to 1
//   en   : debounce enable (the synchronizer runs regardless)
//   din  : raw asynchronous input level
//   q    : debounced, synchronized level
//   notq : complement of q
//   rise : one-cycle pulse after q commits 0->1
//   fall : one-cycle pulse after q commits 1->0
//   busy : high while a candidate transition is being qualified
// master drives set/en/din and observes the conditioned outputs; slave is the conditioner.
interface debounce_sync_if;
  logic set;
  logic en;
  logic din;
  logic q;
  logic notq;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output set,
    output en,
    output din,
    input  q,
    input  notq,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  set,
    input  en,
    input  din,
    output q,
    output notq,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/debounce_sync.sv
// Input conditioner: a SYNC_STAGES-deep synchronizer followed by a counter-based debounce
// FSM. A level change on the synchronized input commits to q only after DEBOUNCE_CYCLES
// consecutive enabled edges that all disagree with q; any agreeing sample in between
// rejects the candidate as a glitch. Commits emit a registered one-cycle rise/fall pulse.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset; has priority over set
//   bus   : debounce_sync_if.slave (set, en, din in; q, notq, rise, fall, busy out)
//
// Asynchronous set mirrors the downstream set/reset flop: it forces q=1 and parks the FSM
// in StStableHi with the counter cleared. The sync chain is not touched by set.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic            clk,
  input logic            reset,
  debounce_sync_if.slave bus
);

  localparam int unsigned CntRaw = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CntW   = (CntRaw < 1) ? 1 : CntRaw;
  // Last count value before a commit; counter never goes past it.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StStableLo,
    StWaitHi,
    StStableHi,
    StWaitLo
  } state_e;

  logic set_async;
  logic en;
  logic din;

  assign set_async = bus.set;
  assign en        = bus.en;
  assign din       = bus.din;

  // Synchronizer

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_q, q_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (en) begin
      unique case (state_q)
        StStableLo: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = StStableHi;
              q_d     = 1'b1;
              rise_d  = 1'b1;
            end else begin
              state_d = StWaitHi;
              cnt_d   = CntW'(1);
            end
          end
        end

        StWaitHi: begin
          if (!s) begin
            // Glitch: abandon the candidate without touching q.
            state_d = StStableLo;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StStableHi;
            cnt_d   = '0;
            q_d     = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        StStableHi: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = StStableLo;
              q_d     = 1'b0;
              fall_d  = 1'b1;
            end else begin
              state_d = StWaitLo;
              cnt_d   = CntW'(1);
            end
          end
        end

        StWaitLo: begin
          if (s) begin
            state_d = StStableHi;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StStableLo;
            cnt_d   = '0;
            q_d     = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end

        default: begin
          state_d = StStableLo;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == StWaitHi) || (state_d == StWaitLo);
  end

  always_ff @(posedge clk or posedge reset or posedge set_async) begin
    if (reset) begin
      state_q <= StStableLo;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (set_async) begin
      state_q <= StStableHi;
      cnt_q   <= '0;
      q_q     <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // Outputs

  // The overrides are also applied at the output so that dropping reset while set is
  // still high shows q=1 immediately, before the flops see another set edge or clock.
  logic override_hi;
  logic override_any;
  logic q_out;

  assign override_hi  = set_async & ~reset;
  assign override_any = set_async | reset;
  assign q_out        = ~reset & (override_hi | q_q);

  // notq is the complement of the same net, so q and notq can never agree.
  assign bus.q    = q_out;
  assign bus.notq = ~q_out;
  assign bus.rise = rise_q & ~override_any;
  assign bus.fall = fall_q & ~override_any;
  assign bus.busy = busy_q & ~override_any;

  // Invariants

`ifndef SYNTHESIS
  a_pulse_excl: assert property (@(posedge clk) disable iff (reset || set_async)
    !(rise_q && fall_q));

  a_cnt_bound: assert property (@(posedge clk) disable iff (reset || set_async)
    cnt_q <= CntLast);

  a_busy_state: assert property (@(posedge clk) disable iff (reset || set_async)
    busy_q == ((state_q == StWaitHi) || (state_q == StWaitLo)));

  a_q_state: assert property (@(posedge clk) disable iff (reset || set_async)
    q_q == ((state_q == StStableHi) || (state_q == StWaitLo)));
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: one instance at default parameters, one with
// DEBOUNCE_CYCLES=1. Outputs are sampled 1 ns after the rising edge; inputs change there.
module tb_debounce_sync;

  logic clk     = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  debounce_sync_if bus_a ();
  debounce_sync_if bus_b ();

  debounce_sync #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  debounce_sync #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (1)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic outs_a(input string tag, input logic eq, input logic er, input logic ef,
                        input logic eb);
    check({tag, " q"}, 32'(bus_a.q), 32'(eq));
    check({tag, " notq"}, 32'(bus_a.notq), 32'(!eq));
    check({tag, " rise"}, 32'(bus_a.rise), 32'(er));
    check({tag, " fall"}, 32'(bus_a.fall), 32'(ef));
    check({tag, " busy"}, 32'(bus_a.busy), 32'(eb));
  endtask

  task automatic outs_b(input string tag, input logic eq, input logic er, input logic ef,
                        input logic eb);
    check({tag, " q"}, 32'(bus_b.q), 32'(eq));
    check({tag, " notq"}, 32'(bus_b.notq), 32'(!eq));
    check({tag, " rise"}, 32'(bus_b.rise), 32'(er));
    check({tag, " fall"}, 32'(bus_b.fall), 32'(ef));
    check({tag, " busy"}, 32'(bus_b.busy), 32'(eb));
  endtask

  task automatic restart_a();
    reset_a     = 1'b1;
    bus_a.set   = 1'b0;
    bus_a.en    = 1'b1;
    bus_a.din   = 1'b0;
    tick(2);
    reset_a = 1'b0;
  endtask

  initial begin
    bus_a.set = 1'b0;
    bus_a.en  = 1'b1;
    bus_a.din = 1'b0;
    bus_b.set = 1'b0;
    bus_b.en  = 1'b1;
    bus_b.din = 1'b0;
    tick(2);

    // 1: reset values, then a clean 0->1 committing on edge 6.
    outs_a("t1 reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1 reset cnt", 32'(dut_a.cnt_q), 0);
    reset_a = 1'b0;
    tick(2);
    bus_a.din = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      outs_a($sformatf("t1 e%0d", e), e >= 6, e == 6, 1'b0, e >= 3 && e <= 5);
    end

    // 2: three-cycle pulse is rejected; counter peaks at 3 then clears.
    restart_a();
    bus_a.din = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3) bus_a.din = 1'b0;
      outs_a($sformatf("t2 e%0d", e), 1'b0, 1'b0, 1'b0, e >= 3 && e <= 5);
      check($sformatf("t2 e%0d cnt", e), 32'(dut_a.cnt_q),
            (e == 3) ? 1 : (e == 4) ? 2 : (e == 5) ? 3 : 0);
    end

    // 3: 3 ns set pulse between edges, then qualification back to 0.
    restart_a();
    tick(3);
    #2 bus_a.set = 1'b1;
    #1 outs_a("t3 set", 1'b1, 1'b0, 1'b0, 1'b0);
    #2 bus_a.set = 1'b0;
    #1 outs_a("t3 rel", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      outs_a($sformatf("t3 e%0d", e), e < 4, 1'b0, e == 4, e <= 3);
    end

    // 4: reset in the middle of WAIT_HI forces a full requalification.
    restart_a();
    bus_a.din = 1'b1;
    tick(4);
    check("t4 pre cnt", 32'(dut_a.cnt_q), 2);
    check("t4 pre busy", 32'(bus_a.busy), 1);
    #1 reset_a = 1'b1;
    #1 outs_a("t4 abort", 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4 abort cnt", 32'(dut_a.cnt_q), 0);
    #1 reset_a = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      outs_a($sformatf("t4 e%0d", e), e == 6, e == 6, 1'b0, e >= 3 && e <= 5);
    end

    // 5: en=0 freezes the counter mid-qualification.
    restart_a();
    bus_a.din = 1'b1;
    tick(4);
    bus_a.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t5 hold%0d cnt", i), 32'(dut_a.cnt_q), 2);
      check($sformatf("t5 hold%0d q", i), 32'(bus_a.q), 0);
    end
    bus_a.en = 1'b1;
    tick();
    outs_a("t5 en e1", 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5 en e1 cnt", 32'(dut_a.cnt_q), 3);
    tick();
    outs_a("t5 en e2", 1'b1, 1'b1, 1'b0, 1'b0);

    // 6a: reset beats set; dropping reset with set held shows q=1 at once.
    bus_a.din = 1'b0;
    reset_a   = 1'b1;
    bus_a.set = 1'b1;
    #2 outs_a("t6 both", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset_a = 1'b0;
    #1 outs_a("t6 set only", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    outs_a("t6 set edge", 1'b1, 1'b0, 1'b0, 1'b0);
    bus_a.set = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      outs_a($sformatf("t6 e%0d", e), e < 4, 1'b0, e == 4, e <= 3);
    end

    // 6b: same override check on the DEBOUNCE_CYCLES=1 instance, then edge-3 commits.
    bus_b.set = 1'b1;
    #1 outs_b("t6b both", 1'b0, 1'b0, 1'b0, 1'b0);
    reset_b = 1'b0;
    #1 outs_b("t6b set only", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bus_b.set = 1'b0;
    tick();
    outs_b("t6b release", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    bus_b.din = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      outs_b($sformatf("t6b up e%0d", e), e >= 3, e == 3, 1'b0, 1'b0);
    end
    bus_b.din = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      outs_b($sformatf("t6b dn e%0d", e), e < 3, 1'b0, e == 3, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
